// File: rtl/systolic_fir_engine.sv
// systolic_fir_engine: streaming FIR with runtime tap RAM, internal delay line,
// registered product stage and binary adder tree, and length-counted runs with done status.
module systolic_fir_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 11,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_tap_we,
    input  logic [$clog2(NUM_TAPS)-1:0] cfg_tap_addr,
    input  logic [DATA_WIDTH-1:0]       cfg_tap_wdata,
    output logic [DATA_WIDTH-1:0]       cfg_tap_rdata,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    output logic                        busy,
    output logic                        done,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [ACC_WIDTH-1:0]        m_data
);
    localparam int LVL = $clog2(NUM_TAPS);
    localparam int PW  = (2 * DATA_WIDTH > ACC_WIDTH) ? 2 * DATA_WIDTH : ACC_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [LEN_WIDTH-1:0]         len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic signed [DATA_WIDTH-1:0] taps_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] taps_d [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] dly_q [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] dly_d [NUM_TAPS];
    logic                         dv_q, dv_d;
    // level 0 holds the products; level LVL holds the final sum in slot 0
    logic [ACC_WIDTH-1:0]         tree_q [LVL+1][2*NUM_TAPS];
    logic [ACC_WIDTH-1:0]         tree_d [LVL+1][2*NUM_TAPS];
    logic [LVL:0]                 tv_q, tv_d;
    logic                         pipe_en, accept, start_acc, tap_wr_ok, last_in, last_out;

    function automatic int width_at(input int l);
        return (NUM_TAPS + (1 << l) - 1) >> l;
    endfunction

    assign m_valid       = tv_q[LVL];
    assign m_data        = tree_q[LVL][0];
    assign pipe_en       = !(m_valid && !m_ready);
    assign accept        = s_valid && s_ready;
    assign start_acc     = start && state_q == IDLE;
    assign last_in       = accept && in_cnt_q == len_q - LEN_WIDTH'(1);
    assign last_out      = m_valid && m_ready && out_cnt_q == len_q - LEN_WIDTH'(1);
    assign tap_wr_ok     = cfg_tap_we && (state_q == IDLE || state_q == DONE) && 32'(cfg_tap_addr) < NUM_TAPS;
    assign cfg_tap_rdata = 32'(cfg_tap_addr) < NUM_TAPS ? taps_q[cfg_tap_addr] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? (len == '0 ? DONE : RUN) : IDLE;
            RUN:     state_d = last_in ? DRAIN : RUN;
            DRAIN:   state_d = last_out ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = state_q == RUN || state_q == DRAIN;
        done    = state_q == DONE;
        s_ready = state_q == RUN && pipe_en;
    end

    always_comb begin
        taps_d    = taps_q;
        dly_d     = dly_q;
        dv_d      = dv_q;
        tree_d    = tree_q;
        tv_d      = tv_q;
        len_d     = len_q;
        in_cnt_d  = accept ? in_cnt_q + LEN_WIDTH'(1) : in_cnt_q;
        out_cnt_d = (m_valid && m_ready) ? out_cnt_q + LEN_WIDTH'(1) : out_cnt_q;
        if (tap_wr_ok)
            taps_d[cfg_tap_addr] = cfg_tap_wdata;
        if (start_acc) begin
            len_d     = len;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            dly_d     = '{default: '0};
        end
        if (pipe_en) begin
            dv_d    = accept;
            tv_d[0] = dv_q;
            if (accept) begin
                dly_d[0] = s_data;
                for (int k = 1; k < NUM_TAPS; k++)
                    dly_d[k] = dly_q[k-1];
            end
            for (int k = 0; k < NUM_TAPS; k++)
                tree_d[0][k] = ACC_WIDTH'(PW'(taps_q[k]) * PW'(dly_q[k]));
            // odd leftover at each level passes through unchanged
            for (int l = 0; l < LVL; l++) begin
                tv_d[l+1] = tv_q[l];
                for (int i = 0; i < NUM_TAPS; i++)
                    tree_d[l+1][i] = (2 * i + 1 < width_at(l)) ? tree_q[l][2*i] + tree_q[l][2*i+1] :
                                     (2 * i < width_at(l))     ? tree_q[l][2*i] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            taps_q    <= '{default: '0};
            dly_q     <= '{default: '0};
            dv_q      <= 1'b0;
            tree_q    <= '{default: '0};
            tv_q      <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            taps_q    <= taps_d;
            dly_q     <= dly_d;
            dv_q      <= dv_d;
            tree_q    <= tree_d;
            tv_q      <= tv_d;
        end
    end
endmodule

// File: tb/tb_systolic_fir_engine.sv
// tb_systolic_fir_engine: directed runs with random data checked against a plain convolution model.
module tb_systolic_fir_engine;
    localparam int N = 11;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cfg_tap_we = 1'b0;
    logic [3:0]  cfg_tap_addr = '0;
    logic [31:0] cfg_tap_wdata = '0, cfg_tap_rdata;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy, done, s_ready, m_valid;
    logic        s_valid = 1'b0, m_ready = 1'b1;
    logic [31:0] s_data = '0, m_data;

    int          passed = 0, total = 0, fails = 0;
    int          h_m [N];
    int          xq [$];
    logic [31:0] last_y = '0;

    systolic_fir_engine dut (
        .clk(clk), .rst(rst),
        .cfg_tap_we(cfg_tap_we), .cfg_tap_addr(cfg_tap_addr),
        .cfg_tap_wdata(cfg_tap_wdata), .cfg_tap_rdata(cfg_tap_rdata),
        .start(start), .len(len), .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tap(input int k, input logic [31:0] v);
        cfg_tap_we    = 1'b1;
        cfg_tap_addr  = 4'(k);
        cfg_tap_wdata = v;
        tick();
        cfg_tap_we = 1'b0;
        if (k < N) h_m[k] = v;
    endtask

    task automatic random_taps();
        for (int k = 0; k < N; k++) write_tap(k, $urandom);
    endtask

    task automatic random_samples(input int n);
        xq.delete();
        for (int i = 0; i < n; i++) xq.push_back($urandom);
    endtask

    task automatic start_run(input int l);
        start = 1'b1;
        len   = 16'(l);
        tick();
        start = 1'b0;
        if (l == 0) begin
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 0);
            chk("len0_m_valid", m_valid, 0);
            tick();
            chk("len0_done_pulse", done, 0);
            chk("len0_no_result", m_valid, 0);
        end else
            chk("start_busy", busy, 1);
    endtask

    // mode 0: always ready, steady input; 1: m_ready toggles; 2: random gaps and random m_ready
    task automatic stream(input int n, input int mode);
        int          ex [$];
        int          y, si, oi, acc_cyc, val_cyc;
        logic        stall, last_hs, got_done;
        logic [31:0] hold;
        for (int t = 0; t < n; t++) begin
            y = 0;
            for (int k = 0; k < N; k++)
                if (t - k >= 0) y += h_m[k] * xq[t-k];
            ex.push_back(y);
        end
        si = 0; oi = 0; acc_cyc = -1; val_cyc = -1;
        stall = 1'b0; last_hs = 1'b0; got_done = 1'b0; hold = '0;
        for (int cyc = 0; cyc < 500 && !got_done; cyc++) begin
            s_valid = si < n && (mode < 2 || $urandom_range(0, 3) != 0);
            s_data  = '0;
            if (si < n) s_data = xq[si];
            m_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (stall) begin
                chk("stall_m_valid", m_valid, 1);
                chk("stall_m_data", m_data, hold);
            end
            stall = m_valid && !m_ready;
            hold  = m_data;
            if (m_valid && val_cyc < 0) val_cyc = cyc;
            if (s_valid && s_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                si++;
            end
            last_hs = 1'b0;
            if (m_valid && m_ready) begin
                if (oi < n) chk($sformatf("result[%0d]", oi), m_data, ex[oi]);
                else chk("extra_result", m_valid, 0);
                last_y  = m_data;
                oi++;
                last_hs = oi == n;
            end
            tick();
            if (last_hs) chk("done_after_last", done, 1);
            got_done = done;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("accepted_count", si, n);
        chk("result_count", oi, n);
        chk("done_seen", got_done, 1);
        if (mode == 0) chk("latency", val_cyc - acc_cyc, 6);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_tap", cfg_tap_rdata, 0);

        for (int k = 0; k < N; k++) write_tap(k, k + 1);
        cfg_tap_addr = 4'd10; #1;
        chk("tap_readback", cfg_tap_rdata, 11);
        cfg_tap_addr = 4'd11; #1;
        chk("tap_oor_read", cfg_tap_rdata, 0);
        write_tap(12, 32'h55);
        cfg_tap_addr = 4'd12; #1;
        chk("tap_oor_write", cfg_tap_rdata, 0);

        xq.delete();
        xq.push_back(1);
        repeat (10) xq.push_back(0);
        start_run(11);
        stream(11, 0);

        random_taps();
        random_samples(20);
        start_run(20);
        stream(20, 1);
        random_taps();
        random_samples(20);
        start_run(20);
        stream(20, 2);

        for (int k = 0; k < N; k++) write_tap(k, 32'h7FFF_FFFF);
        xq.delete();
        repeat (15) xq.push_back(32'h7FFF_FFFF);
        start_run(15);
        stream(15, 1);
        chk("wrap_steady", last_y, 32'd11);

        random_taps();
        start_run(5);
        cfg_tap_we    = 1'b1;
        cfg_tap_addr  = 4'd2;
        cfg_tap_wdata = h_m[2] ^ 32'hFFFF;
        start = 1'b1;
        len   = 16'd1;
        tick();
        cfg_tap_we = 1'b0;
        start = 1'b0;
        #1;
        chk("guard_tap_write", cfg_tap_rdata, h_m[2]);
        chk("guard_busy", busy, 1);
        random_samples(5);
        stream(5, 2);

        start_run(0);

        random_taps();
        random_samples(10);
        start_run(10);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = xq[i];
            tick();
        end
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_m_data", m_data, 0);
        chk("abort_tap", cfg_tap_rdata, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < N; k++) h_m[k] = 0;
        random_taps();
        random_samples(3);
        start_run(3);
        stream(3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
